// File: rtl/md_pkg.sv
// Shared encodings and helpers for the multiply/divide sequencer and the hazard unit.
// Optional feature macro used by the sequencer: MD_DIVZ_DETECT_EN.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int unsigned MD_XLEN  = 32;
  localparam int unsigned DIV_BITS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } md_state_e;

  function automatic logic md_is_op(input logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

  // Hazard unit: while busy, stall any ID instruction that issues here or reads HI/LO.
  function automatic logic md_hazard_stall(input logic busy, input logic id_is_md,
                                           input logic id_is_mfhilo);
    return busy & (id_is_md | id_is_mfhilo);
  endfunction

  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
    logic [31:0] r;
    if (is_signed && v[31]) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Iterative restoring divider on unsigned operands: one quotient bit per clock,
// DIV_BITS iterations after start, remainder/quotient held in one shift register.
module md_div_core
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        valid_o
);

  localparam logic [5:0] LAST_ITER = 6'(DIV_BITS - 1);

  logic [63:0] acc_q, acc_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        valid_q, valid_d;
  logic [32:0] upper_s;
  logic [32:0] diff_s;
  logic [63:0] acc_step_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    upper_s = acc_q[63:31];
    diff_s  = upper_s - {1'b0, dvs_q};
    if (!diff_s[32]) begin
      acc_step_s = {diff_s[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_step_s = {upper_s[31:0], acc_q[30:0], 1'b0};
    end
  end

  // Load on start, otherwise iterate until the last quotient bit is in.
  always_comb begin
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    valid_d = valid_q;
    if (start_i) begin
      acc_d   = {32'd0, dividend_i};
      dvs_d   = divisor_i;
      cnt_d   = 6'd0;
      run_d   = 1'b1;
      valid_d = 1'b0;
    end else if (run_q) begin
      acc_d = acc_step_s;
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == LAST_ITER) begin
        run_d   = 1'b0;
        valid_d = 1'b1;
      end else begin
        run_d   = 1'b1;
        valid_d = 1'b0;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= 64'd0;
      dvs_q   <= 32'd0;
      cnt_q   <= 6'd0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      valid_q <= valid_d;
    end
  end

  assign quotient_o  = acc_q[31:0];
  assign remainder_o = acc_q[63:32];
  assign valid_o     = valid_q;

endmodule

// File: rtl/md_hilo_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and HI/LO owner for the EX stage.
// Optional macro MD_DIVZ_DETECT_EN: adds div_zero and short-circuits divide by zero.
module md_hilo_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef MD_DIVZ_DETECT_EN
  ,
  output logic        div_zero
`endif
);

  localparam bit         MUL_DIRECT = (MUL_LAT == 1);
  localparam logic [5:0] MUL_LAST   = (MUL_LAT > 1) ? 6'(MUL_LAT - 2) : 6'd0;
  localparam logic [5:0] DIV_LAST   = 6'(DIV_BITS - 1);

  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] prod_q, prod_d;
  logic        is_div_q, is_div_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  logic        accept_s;
  logic        is_div_op_s;
  logic        divz_hit_s;
  logic        mul_sgn_s;
  logic [63:0] mul_a_s, mul_b_s, mul_prod_s;
  logic        div_start_s;
  logic [31:0] div_quo_s, div_rem_s;
  logic        div_valid_s;
  logic [31:0] quo_fix_s, rem_fix_s;

  assign accept_s    = md_valid && !busy_q && !flush && md_is_op(md_op);
  assign is_div_op_s = (md_op == MD_DIV) || (md_op == MD_DIVU);

`ifdef MD_DIVZ_DETECT_EN
  assign divz_hit_s = (y == 32'd0);
`else
  assign divz_hit_s = 1'b0;
`endif

  // Low 64 bits of the sign/zero-extended product serve both MULT and MULTU.
  assign mul_sgn_s  = (md_op == MD_MULT);
  assign mul_a_s    = {{32{mul_sgn_s & x[31]}}, x};
  assign mul_b_s    = {{32{mul_sgn_s & y[31]}}, y};
  assign mul_prod_s = mul_a_s * mul_b_s;

  md_div_core u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start_s),
    .dividend_i  (md_abs(x, md_op == MD_DIV)),
    .divisor_i   (md_abs(y, md_op == MD_DIV)),
    .quotient_o  (div_quo_s),
    .remainder_o (div_rem_s),
    .valid_o     (div_valid_s)
  );

  assign quo_fix_s = neg_quo_q ? (32'd0 - div_quo_s) : div_quo_s;
  assign rem_fix_s = neg_rem_q ? (32'd0 - div_rem_s) : div_rem_s;

  // Next-state, counters and HI/LO write selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    prod_d      = prod_q;
    is_div_d    = is_div_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    div_start_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              prod_d   = mul_prod_s;
              is_div_d = 1'b0;
              cnt_d    = 6'd0;
              busy_d   = 1'b1;
              if (MUL_DIRECT) begin
                state_d = S_FIX;
                done_d  = 1'b1;
              end else begin
                state_d = S_MUL;
              end
            end
            MD_DIV, MD_DIVU: begin
              if (divz_hit_s) begin
                busy_d = 1'b0;
              end else begin
                div_start_s = 1'b1;
                is_div_d    = 1'b1;
                state_d     = S_DIV;
                cnt_d       = 6'd0;
                busy_d      = 1'b1;
                neg_quo_d   = (md_op == MD_DIV) & (x[31] ^ y[31]);
                neg_rem_d   = (md_op == MD_DIV) & x[31];
              end
            end
            MD_MTHI: hi_d = x;
            MD_MTLO: lo_d = x;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = 6'd0;
        end else if (cnt_q == MUL_LAST) begin
          state_d = S_FIX;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = 6'd0;
        end else if (cnt_q == DIV_LAST) begin
          state_d = S_FIX;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = 6'd0;
        // A flush landing in FIX suppresses the commit.
        if (!flush) begin
          if (is_div_q) begin
            if (div_valid_s) begin
              hi_d = rem_fix_s;
              lo_d = quo_fix_s;
            end else begin
              hi_d = hi_q;
            end
          end else begin
            hi_d = prod_q[63:32];
            lo_d = prod_q[31:0];
          end
        end else begin
          hi_d = hi_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // Sequencer and HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      prod_q    <= 64'd0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      prod_q    <= prod_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

`ifdef MD_DIVZ_DETECT_EN
  logic divz_q;

  // Divide-by-zero flag pulses for the cycle after the short-circuited accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divz_q <= 1'b0;
    end else begin
      divz_q <= accept_s && is_div_op_s && divz_hit_s;
    end
  end

  assign div_zero = divz_q;
`else
  logic unused_s;
  assign unused_s = is_div_op_s;
`endif

  assign busy = busy_q;
  assign done = done_q & ~flush;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_hilo_sequencer.sv
// Directed self-checking bench for md_hilo_sequencer (default MUL_LAT = 3).
module tb_md_hilo_sequencer;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_valid;
  logic [2:0]  md_op;
  logic [31:0] x;
  logic [31:0] y;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MD_DIVZ_DETECT_EN
  logic        div_zero;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  md_hilo_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .md_valid (md_valid),
    .md_op    (md_op),
    .x        (x),
    .y        (y),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
`ifdef MD_DIVZ_DETECT_EN
    ,
    .div_zero (div_zero)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_valid = 1'b1;
    md_op    = op;
    x        = a;
    y        = b;
    tick();
    md_valid = 1'b0;
    md_op    = MD_NONE;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int cyc = 0;
    int dn  = 0;
    issue(op, a, b);
    while (busy === 1'b1 && cyc < 60) begin
      if (done === 1'b1) dn++;
      cyc++;
      tick();
    end
    check({tag, " busy_cycles"}, 32'(cyc), 32'(lat));
    check({tag, " done_count"}, 32'(dn), 32'd1);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
    check({tag, " done_after"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int dn;
    rst = 1'b1; md_valid = 1'b0; md_op = MD_NONE; x = 32'd0; y = 32'd0; flush = 1'b0;
    #12 rst = 1'b0;
    tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);

    // MTHI/MTLO write at the accept edge, then an async reset clears them.
    issue(MD_MTHI, 32'h0000_1234, 32'd0);
    check("mthi hi", hi, 32'h0000_1234);
    check("mthi busy", {31'd0, busy}, 32'd0);
    issue(MD_MTLO, 32'h0000_1234, 32'd0);
    check("mtlo lo", lo, 32'h0000_1234);
    check("mtlo done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    #1;
    check("async rst hi", hi, 32'd0);
    check("async rst lo", lo, 32'd0);
    check("async rst busy", {31'd0, busy}, 32'd0);
    #2 rst = 1'b0;
    tick();

    run_op("mult -3*7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu ffffffff*2", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 3, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult min*min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 3, 32'h4000_0000, 32'd0);
    run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 7/2", MD_DIVU, 32'd7, 32'd2, 33, 32'd1, 32'd3);
    run_op("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
    run_op("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);

`ifdef MD_DIVZ_DETECT_EN
    issue(MD_MTHI, 32'h0000_00AA, 32'd0);
    issue(MD_MTLO, 32'h0000_00BB, 32'd0);
    issue(MD_DIVU, 32'd5, 32'd0);
    check("divz pulse", {31'd0, div_zero}, 32'd1);
    check("divz busy", {31'd0, busy}, 32'd0);
    tick();
    check("divz pulse end", {31'd0, div_zero}, 32'd0);
    check("divz done", {31'd0, done}, 32'd0);
    check("divz hi", hi, 32'h0000_00AA);
    check("divz lo", lo, 32'h0000_00BB);
`else
    run_op("divu 5/0", MD_DIVU, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF);
`endif

    // Flush ten cycles into a divide: no commit, no done, machine reusable.
    issue(MD_MTHI, 32'h1111_2222, 32'd0);
    issue(MD_MTLO, 32'h3333_4444, 32'd0);
    issue(MD_DIV, 32'd100, 32'd7);
    dn = 0;
    for (int i = 0; i < 9; i++) begin
      if (done === 1'b1) dn++;
      tick();
    end
    check("flush busy before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    if (done === 1'b1) dn++;
    tick();
    flush = 1'b0;
    check("flush busy after", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) dn++;
      tick();
    end
    check("flush done count", 32'(dn), 32'd0);
    check("flush hi kept", hi, 32'h1111_2222);
    check("flush lo kept", lo, 32'h3333_4444);
    run_op("mult after flush", MD_MULT, 32'd6, 32'd7, 3, 32'd0, 32'd42);

    // md_valid held across busy: one accept, one done; next instruction follows.
    md_valid = 1'b1;
    md_op    = MD_MULT;
    x        = 32'd5;
    y        = 32'hFFFF_FFFF;
    tick();
    cyc = 0;
    dn  = 0;
    while (busy === 1'b1 && cyc < 60) begin
      if (done === 1'b1) dn++;
      cyc++;
      tick();
    end
    md_op = MD_MTLO;
    x     = 32'h0000_ABCD;
    tick();
    md_valid = 1'b0;
    md_op    = MD_NONE;
    check("held busy_cycles", 32'(cyc), 32'd3);
    check("held done_count", 32'(dn), 32'd1);
    check("held hi", hi, 32'hFFFF_FFFF);
    check("held mtlo lo", lo, 32'h0000_ABCD);
    check("held busy end", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
